// File: rtl/noc_input_port.sv
// rtl/noc_input_port.sv - NoC router input port: credit-returning flit FIFO, XY route request, wormhole forwarding
module noc_input_port #(
    parameter int         DEPTH = 5,
    parameter logic [3:0] MY_X  = 4'd0,
    parameter logic [3:0] MY_Y  = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        credit_o,
    output logic [4:0]  req_o,
    input  logic        grant_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [4:0]      route_q, route_c;
    logic [15:0]     head;
    logic            empty, full, push, pop, drop, load_route;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign head   = empty ? 16'h0000 : mem[rd_ptr];
    assign push   = valid_i && !full;
    assign data_o = head;

    // X is resolved before Y; ties on both coordinates deliver locally.
    always_comb begin
        route_c = 5'b00001;
        if (head[7:4] > MY_X)
            route_c = 5'b00100;
        else if (head[7:4] < MY_X)
            route_c = 5'b10000;
        else if (head[3:0] > MY_Y)
            route_c = 5'b00010;
        else if (head[3:0] < MY_Y)
            route_c = 5'b01000;
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        drop       = 1'b0;
        load_route = 1'b0;
        req_o      = 5'b00000;
        valid_o    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head[14]) begin
                        load_route = 1'b1;
                        state_nxt  = REQ;
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end
                end
            end
            REQ: begin
                req_o = route_q;
                if (grant_i)
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                req_o   = route_q;
                valid_o = !empty;
                if (!empty && ready_i) begin
                    pop = 1'b1;
                    // bit 15 marks both tail and head+tail
                    if (head[15])
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            route_q  <= 5'b00000;
            credit_o <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit_o <= pop;
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
            if (load_route)
                route_q <= route_c;
            // overflow is judged on the pre-pop count, so a same-cycle pop does not rescue it
            if (drop || (valid_i && full))
                err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_input_port.sv
// tb/tb_noc_input_port.sv - directed bench for noc_input_port against a queue-based packet model
module tb_noc_input_port;
    localparam int         DEPTH = 5;
    localparam logic [3:0] MY_X  = 4'd1;
    localparam logic [3:0] MY_Y  = 4'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_i;
    logic        valid_i;
    logic        credit_o;
    logic [4:0]  req_o;
    logic        grant_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        err_o;

    noc_input_port #(.DEPTH(DEPTH), .MY_X(MY_X), .MY_Y(MY_Y)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i),
        .credit_o(credit_o), .req_o(req_o), .grant_i(grant_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ccnt   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a queue of buffered flits plus "waiting for grant" / "forwarding" flags.
    logic [15:0] q[$];
    bit          m_req = 0, m_fwd = 0, m_credit = 0, m_err = 0;
    logic [4:0]  m_route = '0;

    function automatic logic [4:0] xy(input logic [15:0] f);
        int dx, dy;
        dx = int'(f[7:4]);
        dy = int'(f[3:0]);
        if (dx > int'(MY_X)) return 5'b00100;
        if (dx < int'(MY_X)) return 5'b10000;
        if (dy > int'(MY_Y)) return 5'b00010;
        if (dy < int'(MY_Y)) return 5'b01000;
        return 5'b00001;
    endfunction

    always @(posedge clk) begin : model
        int          sz0;
        logic [15:0] f;
        bit          popped;
        if (rst) begin
            q.delete();
            m_req = 0; m_fwd = 0; m_credit = 0; m_err = 0;
        end else begin
            sz0 = q.size();
            popped = 0;
            if (m_fwd) begin
                if (q.size() > 0 && ready_i) begin
                    f = q.pop_front();
                    popped = 1;
                    if (f[15:14] == 2'b10 || f[15:14] == 2'b11) m_fwd = 0;
                end
            end else if (m_req) begin
                if (grant_i) begin m_req = 0; m_fwd = 1; end
            end else if (q.size() > 0) begin
                if (q[0][15:14] == 2'b01 || q[0][15:14] == 2'b11) begin
                    m_route = xy(q[0]);
                    m_req = 1;
                end else begin
                    f = q.pop_front();
                    popped = 1;
                    m_err = 1;
                end
            end
            if (valid_i) begin
                if (sz0 < DEPTH) q.push_back(data_i);
                else m_err = 1;
            end
            m_credit = popped;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("req_o",    16'(req_o),    16'((m_req || m_fwd) ? m_route : 5'b0));
            chk("valid_o",  16'(valid_o),  16'(m_fwd && q.size() > 0));
            chk("data_o",   data_o,        (q.size() > 0) ? q[0] : 16'h0000);
            chk("credit_o", 16'(credit_o), 16'(m_credit));
            chk("err_o",    16'(err_o),    16'(m_err));
        end
    end

    task automatic tick();
        @(negedge clk);
        if (credit_o === 1'b1) ccnt++;
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic g, input logic r);
        tick();
        valid_i = v; data_i = d; grant_i = g; ready_i = r;
    endtask

    task automatic do_reset();
        step(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] t2 [4] = '{16'h4011, 16'h0AAA, 16'h0BBB, 16'h8CCC};
    logic [15:0] t3 [6] = '{16'h4011, 16'h0001, 16'h0002, 16'h0003, 16'h8004, 16'h0005};
    logic [15:0] t5 [6] = '{16'h4012, 16'h0A01, 16'h0A02, 16'h8A03, 16'h4001, 16'h8077};
    logic [15:0] t6 [3] = '{16'h4011, 16'h0001, 16'h0002};

    initial begin
        rst = 1'b1; valid_i = 1'b0; data_i = '0; grant_i = 1'b0; ready_i = 1'b0;
        tick(); tick();
        chk("rst req_o", 16'(req_o), 16'h0);
        chk("rst valid_o", 16'(valid_o), 16'h0);
        chk("rst credit_o", 16'(credit_o), 16'h0);
        chk("rst err_o", 16'(err_o), 16'h0);
        chk("rst data_o", data_o, 16'h0);
        check_en = 1'b1;
        rst = 1'b0;

        // single-flit packet to East
        for (int c = 0; c < 8; c++) begin
            step(c == 0, 16'hC021, 1'b1, 1'b1);
            if (c == 2) chk("t1 req", 16'(req_o), 16'h0004);
            if (c == 3) begin
                chk("t1 valid", 16'(valid_o), 16'h1);
                chk("t1 data", data_o, 16'hC021);
            end
            if (c == 4) begin
                chk("t1 credit", 16'(credit_o), 16'h1);
                chk("t1 req off", 16'(req_o), 16'h0);
            end
        end

        // 4-flit local packet with a one-cycle stall
        ccnt = 0;
        for (int c = 0; c < 12; c++) begin
            step(c < 4, (c < 4) ? t2[c] : 16'h0, 1'b1, c != 4);
            if (c == 2) chk("t2 req", 16'(req_o), 16'h0001);
            if (c == 4) chk("t2 stall data", data_o, 16'h0AAA);
            if (c == 7) chk("t2 req held", 16'(req_o), 16'h0001);
            if (c == 8) chk("t2 req off", 16'(req_o), 16'h0);
        end
        chk("t2 credits", 16'(ccnt), 16'd4);

        // overflow: 6th flit while full is dropped
        ccnt = 0;
        for (int c = 0; c < 15; c++) begin
            step(c <= 5, (c <= 5) ? t3[c] : 16'h0, 1'b1, c >= 7);
            if (c == 5) chk("t3 err before", 16'(err_o), 16'h0);
            if (c == 6) chk("t3 err", 16'(err_o), 16'h1);
            if (c == 11) chk("t3 tail", data_o, 16'h8004);
        end
        chk("t3 credits", 16'(ccnt), 16'd5);

        do_reset();
        chk("err cleared", 16'(err_o), 16'h0);

        // stray body flit while idle
        ccnt = 0;
        for (int c = 0; c < 5; c++) begin
            step(c == 0, 16'h0123, 1'b0, 1'b1);
            if (c == 1) chk("t4 head", data_o, 16'h0123);
            if (c == 2) begin
                chk("t4 credit", 16'(credit_o), 16'h1);
                chk("t4 err", 16'(err_o), 16'h1);
                chk("t4 data", data_o, 16'h0);
            end
            if (c >= 1) chk("t4 req", 16'(req_o), 16'h0);
        end
        chk("t4 credits", 16'(ccnt), 16'd1);

        do_reset();

        // back-to-back packets, write pointer wraps 4 -> 0
        for (int c = 0; c < 13; c++) begin
            step(c < 6, (c < 6) ? t5[c] : 16'h0, 1'b1, 1'b1);
            if (c == 2) chk("t5 req north", 16'(req_o), 16'h0002);
            if (c == 6) chk("t5 tail a", data_o, 16'h8A03);
            if (c == 7) chk("t5 req gap", 16'(req_o), 16'h0);
            if (c == 8) chk("t5 req west", 16'(req_o), 16'h0010);
            if (c == 10) chk("t5 wrapped", data_o, 16'h8077);
            if (c == 11) chk("t5 req off", 16'(req_o), 16'h0);
        end

        // reset while forwarding with 3 flits buffered
        ccnt = 0;
        for (int c = 0; c < 11; c++) begin
            step(c < 3 || c == 6, (c < 3) ? t6[c] : 16'hC010, 1'b1, c >= 6);
            rst = (c == 4);
            if (c == 3) chk("t6 active", 16'(valid_o), 16'h1);
            if (c == 5) begin
                chk("t6 req", 16'(req_o), 16'h0);
                chk("t6 valid", 16'(valid_o), 16'h0);
                chk("t6 credit", 16'(credit_o), 16'h0);
                chk("t6 data", data_o, 16'h0);
            end
            if (c == 8) chk("t6 req south", 16'(req_o), 16'h0008);
            if (c == 9) chk("t6 data", data_o, 16'hC010);
        end
        chk("t6 credits", 16'(ccnt), 16'd1);

        step(1'b0, 16'h0, 1'b0, 1'b0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
